// File: rtl/regfile_write_port_ctrl_if.sv
// Bundles the ALU, MUL/DIV and register-file write signals of the write-port controller.
// The master side feeds results in; the slave side is the controller itself.
`timescale 1ns/1ps
interface regfile_write_port_ctrl_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic [4:0]        alu_rdi;
    logic [XLEN-1:0]   alu_data;
    logic              alu_stall;
    logic              md_valid;
    logic              md_ready;
    logic [4:0]        md_rdi;
    logic [XLEN-1:0]   md_data;
    logic [XLEN-1:0]   rd;
    logic [4:0]        rdi;
    logic              write_enable;
    logic [31:0]       busy_mask;
    logic [CNT_W-1:0]  fifo_count;

    modport master (
        output alu_valid, alu_rdi, alu_data, md_valid, md_rdi, md_data,
        input  alu_stall, md_ready, rd, rdi, write_enable, busy_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rdi, alu_data, md_valid, md_rdi, md_data,
        output alu_stall, md_ready, rd, rdi, write_enable, busy_mask, fifo_count
    );
endinterface

// File: rtl/regfile_write_port_ctrl.sv
// Merges single-cycle ALU results and FIFO-buffered MUL/DIV results onto one
// registered register-file write port, with a starvation guard for the FIFO head.
`timescale 1ns/1ps
module regfile_write_port_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_port_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] S_NORMAL = 1'b0;
    localparam logic [0:0] S_DRAIN  = 1'b1;

    typedef struct packed {
        logic [4:0]      rdi;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t            mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] vld_q, vld_n;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [0:0]        state_q, state_n;
    logic [STV_W-1:0]  starve_q, starve_n;
    logic              stall_q;
    logic [XLEN-1:0]   rd_q;
    logic [4:0]        rdi_q;
    logic              we_q;
    logic [31:0]       busy_q, busy_n;
    logic [4:0]        slot_rdi;

    logic full, empty, ready, push, pop, sel_alu, alu_eff;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign ready   = rst_n & ~full;
    assign push    = bus.md_valid & ready & (bus.md_rdi != 5'd0);
    assign alu_eff = bus.alu_valid & (bus.alu_rdi != 5'd0);

    // Arbitration: ALU first unless the FIFO head has lost STARVE_LIMIT times in a row.
    always_comb begin
        state_n  = state_q;
        starve_n = starve_q;
        pop      = 1'b0;
        sel_alu  = 1'b0;
        case (state_q)
            S_NORMAL: begin
                if (alu_eff) begin
                    sel_alu = 1'b1;
                    if (empty) begin
                        starve_n = '0;
                    end else if (starve_q == STV_W'(STARVE_LIMIT - 1)) begin
                        state_n  = S_DRAIN;
                        starve_n = '0;
                    end else begin
                        starve_n = starve_q + STV_W'(1);
                    end
                end else begin
                    pop      = ~empty;
                    starve_n = '0;
                end
            end
            S_DRAIN: begin
                pop      = ~empty;
                starve_n = '0;
                state_n  = S_NORMAL;
            end
            default: begin
                state_n  = S_NORMAL;
                starve_n = '0;
            end
        endcase
    end

    // Pending-write mask from the post-edge FIFO contents.
    always_comb begin
        vld_n    = vld_q;
        busy_n   = '0;
        slot_rdi = '0;
        if (pop)  vld_n[rd_ptr] = 1'b0;
        if (push) vld_n[wr_ptr] = 1'b1;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            slot_rdi = (push && (wr_ptr == PTR_W'(i))) ? bus.md_rdi : mem[i].rdi;
            if (vld_n[i]) busy_n[slot_rdi] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rdi: bus.md_rdi, data: bus.md_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_NORMAL;
            starve_q <= '0;
            stall_q  <= 1'b0;
            vld_q    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            rd_q     <= '0;
            rdi_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_n;
            starve_q <= starve_n;
            stall_q  <= (state_n == S_DRAIN);
            vld_q    <= vld_n;
            busy_q   <= busy_n;
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (sel_alu) begin
                rd_q  <= bus.alu_data;
                rdi_q <= bus.alu_rdi;
                we_q  <= 1'b1;
            end else if (pop) begin
                rd_q  <= mem[rd_ptr].data;
                rdi_q <= mem[rd_ptr].rdi;
                we_q  <= 1'b1;
            end else begin
                we_q  <= 1'b0;
            end
        end
    end

    assign bus.md_ready     = ready;
    assign bus.alu_stall    = stall_q;
    assign bus.rd           = rd_q;
    assign bus.rdi          = rdi_q;
    assign bus.write_enable = we_q;
    assign bus.busy_mask    = busy_q;
    assign bus.fifo_count   = count_q;
endmodule

// File: tb/tb_regfile_write_port_ctrl.sv
// Bench for regfile_write_port_ctrl: directed vector table, corner sequences and
// random traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_regfile_write_port_ctrl;
    localparam int DEPTH = 4;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_write_port_ctrl_if #(.XLEN(32), .FIFO_DEPTH(DEPTH)) bus ();

    regfile_write_port_ctrl #(.XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the FIFO is a queue, arbitration follows the written rules directly.
    typedef struct { logic [4:0] rdi; logic [31:0] data; } ent_t;
    ent_t        q[$];
    int          m_starve;
    bit          m_force;
    bit          m_we;
    logic [4:0]  m_rdi;
    logic [31:0] m_rd;
    bit          last_alu_acc;
    bit          last_md_acc;

    task automatic model_reset();
        q.delete();
        m_starve = 0; m_force = 0; m_we = 0; m_rdi = '0; m_rd = '0;
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (q[i]) b[q[i].rdi] = 1'b1;
        return b;
    endfunction

    task automatic model_update(input bit av, input logic [4:0] ardi, input logic [31:0] adata,
                                input bit mv, input logic [4:0] mrdi, input logic [31:0] mdata);
        bit   hs = mv && (q.size() < DEPTH);
        ent_t e;
        if (m_force && q.size() > 0) begin
            e = q.pop_front(); m_we = 1; m_rdi = e.rdi; m_rd = e.data;
            m_force = 0; m_starve = 0;
        end else if (!m_force && av && ardi != 0) begin
            m_we = 1; m_rdi = ardi; m_rd = adata;
            if (q.size() > 0) begin
                m_starve++;
                if (m_starve == LIMIT) begin m_force = 1; m_starve = 0; end
            end else m_starve = 0;
        end else if (q.size() > 0) begin
            e = q.pop_front(); m_we = 1; m_rdi = e.rdi; m_rd = e.data; m_starve = 0;
            m_force = 0;
        end else begin
            m_we = 0; m_starve = 0; m_force = 0;
        end
        if (hs && mrdi != 0) q.push_back('{rdi: mrdi, data: mdata});
    endtask

    // One clock: optional pre-edge checks, edge, model step, optional post-edge checks.
    task automatic tick(input bit chk);
        bit ready_pre, stall_pre;
        #1;
        ready_pre = (q.size() < DEPTH);
        stall_pre = m_force;
        if (chk) begin
            check("md_ready", 32'(bus.md_ready), 32'(ready_pre));
            check("alu_stall_pre", 32'(bus.alu_stall), 32'(stall_pre));
        end
        last_alu_acc = !stall_pre;
        last_md_acc  = bus.md_valid && ready_pre;
        @(posedge clk); #1;
        model_update(bus.alu_valid, bus.alu_rdi, bus.alu_data, bus.md_valid, bus.md_rdi, bus.md_data);
        if (chk) begin
            check("write_enable", 32'(bus.write_enable), 32'(m_we));
            check("rdi", 32'(bus.rdi), 32'(m_rdi));
            check("rd", bus.rd, m_rd);
            check("busy_mask", bus.busy_mask, m_busy());
            check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
            check("alu_stall", 32'(bus.alu_stall), 32'(m_force));
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_rdi = '0; bus.alu_data = '0;
        bus.md_valid = 0;  bus.md_rdi = '0;  bus.md_data = '0;
    endtask

    typedef struct {
        logic av; logic [4:0] ardi; logic [31:0] adata;
        logic mv; logic [4:0] mrdi; logic [31:0] mdata;
        logic e_we; logic [4:0] e_rdi; logic [31:0] e_rd; logic [31:0] e_busy; int e_cnt;
    } vec_t;
    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1, 5'd4, 32'h12345, 1'b0, 5'd0, 32'h0,     1'b1, 5'd4, 32'h12345, 32'h0,  0};
        vecs[1] = '{1'b1, 5'd0, 32'hdead,  1'b0, 5'd0, 32'h0,     1'b0, 5'd4, 32'h12345, 32'h0,  0};
        vecs[2] = '{1'b1, 5'd1, 32'h11,    1'b1, 5'd3, 32'h98765, 1'b1, 5'd1, 32'h11,    32'h08, 1};
        vecs[3] = '{1'b1, 5'd2, 32'h22,    1'b1, 5'd5, 32'h1,     1'b1, 5'd2, 32'h22,    32'h28, 2};
        vecs[4] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b1, 5'd3, 32'h98765, 32'h20, 1};
        vecs[5] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b1, 5'd5, 32'h1,     32'h0,  0};
        vecs[6] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b0, 5'd5, 32'h1,     32'h0,  0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,     1'b1, 5'd0, 32'h55,    1'b0, 5'd5, 32'h1,     32'h0,  0};
        vecs[8] = '{1'b0, 5'd0, 32'h0,     1'b0, 5'd0, 32'h0,     1'b0, 5'd5, 32'h1,     32'h0,  0};

        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        check("rst_we", 32'(bus.write_enable), 32'h0);
        check("rst_rd", bus.rd, 32'h0);
        check("rst_rdi", 32'(bus.rdi), 32'h0);
        check("rst_busy", bus.busy_mask, 32'h0);
        check("rst_count", 32'(bus.fifo_count), 32'h0);
        check("rst_stall", 32'(bus.alu_stall), 32'h0);
        check("rst_md_ready", 32'(bus.md_ready), 32'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Directed vectors: ALU-only, x0 suppression, MD buffering and drain order.
        for (int i = 0; i < 9; i++) begin
            bus.alu_valid = vecs[i].av; bus.alu_rdi = vecs[i].ardi; bus.alu_data = vecs[i].adata;
            bus.md_valid = vecs[i].mv;  bus.md_rdi = vecs[i].mrdi;  bus.md_data = vecs[i].mdata;
            #1;
            check($sformatf("vec%0d_md_ready", i), 32'(bus.md_ready), 32'h1);
            tick(0);
            check($sformatf("vec%0d_we", i), 32'(bus.write_enable), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_rdi", i), 32'(bus.rdi), 32'(vecs[i].e_rdi));
            check($sformatf("vec%0d_rd", i), bus.rd, vecs[i].e_rd);
            check($sformatf("vec%0d_busy", i), bus.busy_mask, vecs[i].e_busy);
            check($sformatf("vec%0d_count", i), 32'(bus.fifo_count), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d_stall", i), 32'(bus.alu_stall), 32'h0);
        end

        // Starvation: x7 waits behind a continuous ALU stream, then forces one drain cycle.
        bus.alu_valid = 1; bus.alu_rdi = 5'd9; bus.alu_data = 32'h900;
        bus.md_valid = 1;  bus.md_rdi = 5'd7;  bus.md_data = 32'h777;
        tick(1);
        bus.md_valid = 0;
        for (int i = 1; i <= 6; i++) begin
            if (last_alu_acc) bus.alu_data = bus.alu_data + 32'h1;
            tick(1);
            if (i == 4) check("starve_stall_on", 32'(bus.alu_stall), 32'h1);
            if (i == 5) begin
                check("starve_drain_rdi", 32'(bus.rdi), 32'h7);
                check("starve_drain_rd", bus.rd, 32'h777);
            end
            if (i == 6) check("starve_held_alu_rd", bus.rd, 32'h905);
        end
        idle_inputs();
        tick(1);

        // Full FIFO: a fifth result is held off by md_ready and retires last.
        begin
            int j = 0;
            bus.alu_rdi = 5'd20; bus.alu_data = 32'ha00;
            for (int c = 0; c < 12; c++) begin
                if (c > 0 && last_alu_acc) bus.alu_data = bus.alu_data + 32'h1;
                bus.alu_valid = (c < 7);
                bus.md_valid  = (j < 5);
                bus.md_rdi    = 5'(10 + j);
                bus.md_data   = 32'h1000 + 32'(j);
                tick(1);
                if (last_md_acc) j++;
                if (c == 3) begin
                    check("full_count", 32'(bus.fifo_count), 32'd4);
                    check("full_md_ready", 32'(bus.md_ready), 32'h0);
                end
                if (c == 4) check("full_count_held", 32'(bus.fifo_count), 32'd4);
                if (c == 5) check("full_first_out", 32'(bus.rdi), 32'd10);
                if (c == 10) check("full_last_out", 32'(bus.rdi), 32'd14);
            end
            check("full_all_accepted", 32'(j), 32'd5);
        end
        idle_inputs();

        // Reset while entries are draining.
        bus.alu_valid = 1; bus.alu_rdi = 5'd21; bus.alu_data = 32'hb00;
        for (int c = 0; c < 3; c++) begin
            bus.md_valid = 1; bus.md_rdi = 5'(c + 1); bus.md_data = 32'h2000 + 32'(c);
            tick(1);
        end
        idle_inputs();
        tick(1);
        #2 rst_n = 0;
        #1;
        check("mid_rst_we", 32'(bus.write_enable), 32'h0);
        check("mid_rst_count", 32'(bus.fifo_count), 32'h0);
        check("mid_rst_busy", bus.busy_mask, 32'h0);
        check("mid_rst_md_ready", 32'(bus.md_ready), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) tick(1);

        // Random traffic with upstream hold on stall / not-ready.
        for (int c = 0; c < 400; c++) begin
            if (!(bus.alu_valid && !last_alu_acc)) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_rdi   = 5'($urandom_range(0, 31));
                bus.alu_data  = $urandom;
            end
            if (!(bus.md_valid && !last_md_acc)) begin
                bus.md_valid = ($urandom_range(0, 9) < 4);
                bus.md_rdi   = 5'($urandom_range(0, 31));
                bus.md_data  = $urandom;
            end
            tick(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
